// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Types and constants shared by the front end of the CPU.
//   ADDR_W / INSTR_W : PC / byte-address width and instruction width
//   INSTR_NOP        : value held in an empty instruction slot
//   fetch_entry_t    : one fetched word together with its byte address
package cpu_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h00000000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
//   Two-entry in-order buffer between the instruction memory response and
//   the decoder: an output register that drives the consumer plus one skid
//   register that catches a word arriving while the output is held.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard both entries (beats push)
//   push       : push_data is written this cycle
//   push_data  : {pc, instr} entry being written
//   pop        : consumer takes out_data this cycle (only meaningful with out_valid)
//   out_valid  : out_data holds a valid entry
//   out_data   : oldest entry
//   occ        : number of valid entries (0..2)
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         out_valid,
    output fetch_entry_t out_data,
    output logic [1:0]   occ
);

    fetch_entry_t out_reg, out_next;
    fetch_entry_t skid_reg, skid_next;
    logic         out_v_reg, out_v_next;
    logic         skid_v_reg, skid_v_next;
    logic         out_free;

    // The output slot can take a new entry if it is empty or being popped.
    assign out_free = !out_v_reg || pop;

    always_comb begin
        out_next    = out_reg;
        skid_next   = skid_reg;
        out_v_next  = out_v_reg;
        skid_v_next = skid_v_reg;

        if (flush) begin
            out_v_next  = 1'b0;
            skid_v_next = 1'b0;
        end else if (out_free) begin
            if (skid_v_reg) begin
                // Skid is older than any incoming word, so it refills the
                // output first and the new word (if any) takes its place.
                out_next    = skid_reg;
                out_v_next  = 1'b1;
                skid_v_next = push;
                if (push) begin
                    skid_next = push_data;
                end
            end else begin
                out_v_next = push;
                if (push) begin
                    out_next = push_data;
                end
            end
        end else if (push) begin
            // Output is held; the issue logic guarantees the skid is empty here.
            skid_next   = push_data;
            skid_v_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg    <= '0;
            skid_reg   <= '0;
            out_v_reg  <= 1'b0;
            skid_v_reg <= 1'b0;
        end else begin
            out_reg    <= out_next;
            skid_reg   <= skid_next;
            out_v_reg  <= out_v_next;
            skid_v_reg <= skid_v_next;
        end
    end

    assign out_valid = out_v_reg;
    assign out_data  = out_reg;
    assign occ       = {1'b0, out_v_reg} + {1'b0, skid_v_reg};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage in front of a 1-cycle registered instruction
//   memory. Owns the PC, tracks the word in flight, buffers up to two
//   fetched words and hands {pc, instr} to the decoder over valid/ready.
//   Widths come from cpu_pkg (ADDR_W, INSTR_W).
// Parameters
//   RESET_PC    : PC loaded on reset
//   IMEM_BYTES  : memory size; fetching from pc > IMEM_BYTES-4 faults
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : byte address to memory (= current PC)
//   imem_instr      : memory data, valid the cycle after imem_addr was sampled
//   redirect_valid  : branch/jump taken; redirect_pc is the target
//   redirect_pc     : redirect target byte address
//   if_valid        : if_instr / if_pc / if_pc_plus4 hold a fetched word
//   if_ready        : decoder accepts this cycle
//   if_instr        : fetched instruction
//   if_pc           : byte address of if_instr
//   if_pc_plus4     : if_pc + 4 (zero while if_valid is low)
//   fetch_fault     : sticky misaligned / out-of-range fault; halts fetch
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                IMEM_BYTES = 128
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    output logic               fetch_fault
);

    localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(IMEM_BYTES - 4);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
    logic              resp_v_reg, resp_v_next;
    logic              fault_reg, fault_next;

    logic              pop;
    logic              can_issue;
    logic              range_fault;
    logic              align_fault;
    logic              issue;
    logic [1:0]        buf_occ;
    logic [1:0]        occ_total;
    logic [1:0]        occ_after_pop;

    logic              buf_valid;
    fetch_entry_t      buf_data;
    fetch_entry_t      resp_entry;

    assign pop = buf_valid && if_ready;

    // Buffered words plus the word in flight never exceed two, so a 2-bit
    // count is enough. Issue only if the landing word will have a slot.
    assign occ_total     = buf_occ + {1'b0, resp_v_reg};
    assign occ_after_pop = occ_total - {1'b0, pop};

    assign can_issue   = !redirect_valid && !fault_reg && (occ_after_pop < 2'd2);
    assign range_fault = can_issue && (pc_reg > PC_LIMIT);
    assign issue       = can_issue && !range_fault;
    assign align_fault = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        pc_next      = pc_reg;
        resp_v_next  = 1'b0;
        resp_pc_next = resp_pc_reg;
        fault_next   = fault_reg | align_fault | range_fault;

        if (redirect_valid) begin
            // The word in flight is dropped by leaving resp_v low.
            pc_next = redirect_pc;
        end else if (issue) begin
            pc_next      = pc_reg + ADDR_W'(4);
            resp_v_next  = 1'b1;
            resp_pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            resp_pc_reg <= '0;
            resp_v_reg  <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            resp_pc_reg <= resp_pc_next;
            resp_v_reg  <= resp_v_next;
            fault_reg   <= fault_next;
        end
    end

    assign resp_entry = '{pc: resp_pc_reg, instr: imem_instr};

    // A redirect flushes the buffer, which also discards a word landing
    // in the same cycle.
    fetch_skid_buf u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_v_reg),
        .push_data (resp_entry),
        .pop       (pop),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .occ       (buf_occ)
    );

    assign imem_addr   = pc_reg;
    assign if_valid    = buf_valid;
    assign if_instr    = buf_data.instr;
    assign if_pc       = buf_data.pc;
    assign if_pc_plus4 = buf_valid ? (buf_data.pc + ADDR_W'(4)) : '0;
    assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int IMEM_BYTES = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    // 1-cycle registered instruction memory
    logic [31:0] mem [0:31];

    always @(posedge clk) begin
        if (imem_addr < 32'd128 && imem_addr[1:0] == 2'b00)
            imem_instr <= mem[imem_addr[6:2]];
        else
            imem_instr <= 32'hDEADBEEF;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] last_pop_pc = 32'hFFFFFFFF;

    // Monitor: every accepted word must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if_valid && if_ready) begin
            vectors++;
            last_pop_pc = if_pc;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pop: got pc=%h instr=%h, required no pop", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr || if_pc_plus4 !== e.pc + 32'd4) begin
                    miscompares++;
                    $display("FAIL pop: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                             if_pc, if_instr, if_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
                end else begin
                    $display("pop pc=%h instr=%h pc4=%h ok", if_pc, if_instr, if_pc_plus4);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.pc    = 32'(a);
        e.instr = mem[a / 4];
        exp_q.push_back(e);
    endtask

    // Leaves rst deasserted #1 after a posedge; first issue is at the next edge.
    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 32'h11000000 | 32'(i * 4);
        mem[0] = 32'h00000000;
        mem[1] = 32'h34020026;
        mem[2] = 32'h34030034;
        mem[3] = 32'h00628020;
        mem[4] = 32'hae020001;
        mem[5] = 32'h8e030001;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_if_pc_plus4", if_pc_plus4, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_imem_addr", imem_addr, 0);

        // 1: steady streaming from reset
        for (int a = 0; a <= 20; a += 4) push_exp(a);
        rst      = 1'b0;
        if_ready = 1'b1;
        tick();
        check("t1_valid_cycle1", if_valid, 0);
        tick();
        check("t1_valid_cycle2", if_valid, 1);
        drain(20, n);
        check("t1_pop_cycles", n, 6);
        if_ready = 1'b0;

        // 2: stall while pc 8 is presented
        do_reset();
        push_exp(0);
        push_exp(4);
        if_ready = 1'b1;
        drain(20, n);
        if_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("t2_stall_valid", if_valid, 1);
            check("t2_stall_pc", if_pc, 8);
            check("t2_stall_instr", if_instr, 32'h34030034);
            check("t2_stall_imem_addr", imem_addr, 16);
            tick();
        end
        for (int a = 8; a <= 20; a += 4) push_exp(a);
        if_ready = 1'b1;
        drain(20, n);
        if_ready = 1'b0;

        // 3: redirect to 4 while pc 16 is presented
        do_reset();
        for (int a = 0; a <= 12; a += 4) push_exp(a);
        if_ready = 1'b1;
        drain(20, n);
        check("t3_pre_pc", if_pc, 16);
        push_exp(16);
        push_exp(4);
        push_exp(8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        tick();
        redirect_valid = 1'b0;
        check("t3_valid_r1", if_valid, 0);
        tick();
        check("t3_valid_r2", if_valid, 0);
        tick();
        check("t3_valid_r3", if_valid, 1);
        check("t3_pc_r3", if_pc, 4);
        check("t3_instr_r3", if_instr, 32'h34020026);
        drain(20, n);
        if_ready = 1'b0;

        // 4: misaligned redirect target
        do_reset();
        repeat (4) tick();
        check("t4_fill_valid", if_valid, 1);
        check("t4_fill_pc", if_pc, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        check("t4_fault", fetch_fault, 1);
        check("t4_valid", if_valid, 0);
        check("t4_imem_addr", imem_addr, 6);
        repeat (3) tick();
        check("t4_fault_sticky", fetch_fault, 1);
        check("t4_valid_later", if_valid, 0);
        check("t4_imem_addr_later", imem_addr, 6);
        rst = 1'b1;
        tick();
        check("t4_fault_cleared", fetch_fault, 0);
        rst = 1'b0;

        // 5: run off the end of memory
        do_reset();
        for (int a = 0; a <= 124; a += 4) push_exp(a);
        if_ready = 1'b1;
        drain(100, n);
        check("t5_pop_cycles", n, 34);
        repeat (4) tick();
        check("t5_fault", fetch_fault, 1);
        check("t5_valid", if_valid, 0);
        check("t5_imem_addr", imem_addr, 128);
        check("t5_last_pc", last_pop_pc, 124);
        if_ready = 1'b0;

        // 6: reset in the middle of a stall with the skid full
        do_reset();
        repeat (4) tick();
        check("t6_stall_valid", if_valid, 1);
        check("t6_stall_imem_addr", imem_addr, 8);
        rst = 1'b1;
        tick();
        check("t6_valid", if_valid, 0);
        check("t6_pc", if_pc, 0);
        check("t6_instr", if_instr, 0);
        check("t6_pc_plus4", if_pc_plus4, 0);
        check("t6_imem_addr", imem_addr, 0);
        check("t6_fault", fetch_fault, 0);
        rst = 1'b0;
        tick();
        check("t6_valid_after", if_valid, 0);
        tick();
        check("t6_refill_valid", if_valid, 1);
        check("t6_refill_pc", if_pc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
